mtm_alu_deserializer_out: RTL
=============================

Name: mtm_alu_deserializer_out

Overview:
- Receiver for the ALU result serial line; the opposite end of the output serializer.
- Samples one bit per clk and rebuilds the frame from 11-bit byte packets. Each packet is: start bit 0, packet-type bit (0 = data, 1 = control), 8 payload bits MSB first, stop bit 1.
- Delivers the 32-bit result C plus its 8-bit CTL byte, or an error-only CTL byte.
- Used in the verification environment and in loopback builds; it checks framing and the CTL CRC.

Parameters:
- DATA_BYTES, 4, number of data packets preceding the control packet in a result frame.
- CTL_W, 8, width of the control byte.

Ports:
- clk  input  1  system clock; one serial bit per rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial line; idles high.
- C_out  output  32  received result; first data byte lands in C_out[31:24].
- CTL_rx  output  8  received control byte.
- result_valid  output  1  1-cycle pulse: valid result frame received.
- err_valid  output  1  1-cycle pulse: error-only frame received.
- crc_ok  output  1  CRC check result for the last result frame; stable until the next result_valid.
- frame_err  output  1  1-cycle pulse: malformed frame discarded.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE; bit_cnt=0; byte_cnt=0; shift and assembly registers cleared.
  - All outputs 0: C_out, CTL_rx, result_valid, err_valid, crc_ok, frame_err.
  - Reset mid-frame discards the partial frame. No pulse is generated for it.
- States:
  - IDLE: sin=0 -> PKT; otherwise stay.
  - PKT: latch sin as is_ctl -> DATA; bit_cnt=0.
  - DATA: shift sin into byte_sr (MSB first). At bit_cnt==7 -> STOP; otherwise bit_cnt+1.
  - STOP: sin=1 -> commit byte (rules below) -> IDLE. sin=0 -> frame_err, clear byte_cnt -> HUNT.
  - HUNT: wait for sin=1 -> IDLE. This prevents a stuck-low line from retriggering.
- Byte commit rules:
  - Data packet with byte_cnt<DATA_BYTES: store into C assembly at byte index byte_cnt; byte_cnt+1.
  - Data packet with byte_cnt==DATA_BYTES: frame_err; byte_cnt=0.
  - Control packet with byte_cnt==DATA_BYTES and byte[7]==0: C_out and CTL_rx updated; result_valid pulse; crc_ok updated; byte_cnt=0.
  - Control packet with byte_cnt==0 and byte[7]==1: CTL_rx updated; err_valid pulse; C_out held; crc_ok held.
  - Any other control packet (1..3 data bytes seen, or byte[7] mismatch): frame_err; byte_cnt=0; outputs held.
- Latency: pulses assert on the clk edge after the stop bit is sampled. Exactly one pulse per frame outcome.
- Back-to-back packets: a start bit may directly follow a stop bit (no idle gap). The IDLE state detects it on the next sample.
- A gap of any length between packets of one frame is tolerated.
- CRC:
  - CRC-3, polynomial x^3+x+1, init 000.
  - Input: 37 bits {C[31:0], 1'b0, CTL[6:3]}, MSB first.
  - crc_ok = (crc == CTL[2:0]).
  - Computed combinationally from the assembled C and the received CTL at commit, then registered.
- Counters: bit_cnt 3 bits; byte_cnt 3 bits, saturating check at DATA_BYTES with no wrap.

Decomposition:
- Shared package mtm_alu_pkg:
  - state enum (IDLE, PKT, DATA, STOP, HUNT).
  - PKT_DATA=0, PKT_CTL=1.
  - error CTL codes 8'b11001001, 8'b10010011, 8'b10100101.
  - CRC3 polynomial constant.
- Sub-module mtm_alu_crc3: combinational 37-bit CRC-3 generator, reusable by the ALU core.

Test Plan:
- Result frame: 4 data packets 0xDE, 0xAD, 0xBE, 0xEF, then a control packet carrying the correct CTL for 0xDEADBEEF. Required: result_valid=1 for one cycle, C_out=0xDEADBEEF, CTL_rx matches, crc_ok=1.
- Same frame with CTL[0] flipped -> result_valid pulses, crc_ok=0.
- Error-only frame: a single control packet 0xC9 -> err_valid pulse, CTL_rx=0xC9, C_out unchanged, no result_valid.
- Stop bit forced to 0 in the 2nd data packet -> frame_err pulse. sin then held low for 20 cycles -> no further events. Line released, then a valid frame -> correct result_valid.
- Control packet after only 2 data packets -> frame_err. A 5th data packet in place of control -> frame_err. Both followed by a valid frame to show recovery.
- rst=1 for one cycle mid-way through the 3rd data packet -> all outputs 0, no pulses. A following complete frame decodes correctly. Two frames sent with no idle gap -> two result_valid pulses.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU serial link.
// Used by the result deserializer and the CRC-3 generator.
package mtm_alu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPkt,
      StData,
      StStop,
      StHunt
   } state_t;

   localparam logic PKT_DATA = 1'b0;
   localparam logic PKT_CTL  = 1'b1;

   // Error-only CTL bytes; bit 7 set marks them as error frames.
   localparam logic [7:0] ERR_DATA = 8'b1100_1001;
   localparam logic [7:0] ERR_OP   = 8'b1001_0011;
   localparam logic [7:0] ERR_CRC  = 8'b1010_0101;

   // x^3 + x + 1 with the x^3 term implicit.
   localparam logic [2:0] CRC3_POLY = 3'b011;

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC-3 (x^3+x+1, init 000) over a 37-bit word, MSB first.
// Shared between the result deserializer and the ALU core.
module mtm_alu_crc3
   import mtm_alu_pkg::*;
(
   input  logic [36:0] data,
   output logic [2:0]  crc
);

   logic [2:0] c;
   logic       fb;

   always_comb begin
      c  = 3'b000;
      fb = 1'b0;
      for (int i = 36; i >= 0; i--) begin
         fb = c[2] ^ data[i];
         c  = {c[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
      end
   end

   assign crc = c;

endmodule

// File: rtl/mtm_alu_deserializer_out.sv
// Receives the ALU result serial line: 11-bit packets, framing checks,
// result / error-only frame delivery and CTL CRC verification.
module mtm_alu_deserializer_out
   import mtm_alu_pkg::*;
#(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned CTL_W      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sin,
   output logic [8*DATA_BYTES-1:0]   C_out,
   output logic [CTL_W-1:0]          CTL_rx,
   output logic                      result_valid,
   output logic                      err_valid,
   output logic                      crc_ok,
   output logic                      frame_err
);

   localparam int unsigned C_W = 8 * DATA_BYTES;
   localparam logic [2:0]  FULL_CNT = 3'(DATA_BYTES);

   state_t                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             byte_cnt_q, byte_cnt_d;
   logic                   is_ctl_q, is_ctl_d;
   logic [7:0]             byte_sr_q, byte_sr_d;
   logic [C_W-1:0]         c_asm_q, c_asm_d;
   logic [C_W-1:0]         c_out_q, c_out_d;
   logic [CTL_W-1:0]       ctl_q, ctl_d;
   logic                   crc_ok_q, crc_ok_d;
   logic                   result_valid_q, result_valid_d;
   logic                   err_valid_q, err_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [2:0]             crc_calc;

   mtm_alu_crc3 u_crc (
      .data ({c_asm_q, 1'b0, byte_sr_q[6:3]}),
      .crc  (crc_calc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         bit_cnt_q      <= '0;
         byte_cnt_q     <= '0;
         is_ctl_q       <= 1'b0;
         byte_sr_q      <= '0;
         c_asm_q        <= '0;
         c_out_q        <= '0;
         ctl_q          <= '0;
         crc_ok_q       <= 1'b0;
         result_valid_q <= 1'b0;
         err_valid_q    <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         byte_cnt_q     <= byte_cnt_d;
         is_ctl_q       <= is_ctl_d;
         byte_sr_q      <= byte_sr_d;
         c_asm_q        <= c_asm_d;
         c_out_q        <= c_out_d;
         ctl_q          <= ctl_d;
         crc_ok_q       <= crc_ok_d;
         result_valid_q <= result_valid_d;
         err_valid_q    <= err_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      byte_cnt_d     = byte_cnt_q;
      is_ctl_d       = is_ctl_q;
      byte_sr_d      = byte_sr_q;
      c_asm_d        = c_asm_q;
      c_out_d        = c_out_q;
      ctl_d          = ctl_q;
      crc_ok_d       = crc_ok_q;
      result_valid_d = 1'b0;
      err_valid_d    = 1'b0;
      frame_err_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!sin) state_d = StPkt;
         end
         StPkt: begin
            is_ctl_d  = sin;
            bit_cnt_d = 3'd0;
            state_d   = StData;
         end
         StData: begin
            byte_sr_d = {byte_sr_q[6:0], sin};
            if (bit_cnt_q == 3'd7) state_d = StStop;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
         end
         StStop: begin
            if (sin) begin
               state_d = StIdle;
               if (is_ctl_q == PKT_DATA) begin
                  if (byte_cnt_q < FULL_CNT) begin
                     // Every frame starts at byte_cnt 0, so shifting lands byte 0 in the MSBs.
                     c_asm_d    = {c_asm_q[C_W-9:0], byte_sr_q};
                     byte_cnt_d = byte_cnt_q + 3'd1;
                  end else begin
                     frame_err_d = 1'b1;
                     byte_cnt_d  = 3'd0;
                  end
               end else if (byte_cnt_q == FULL_CNT && !byte_sr_q[7]) begin
                  c_out_d        = c_asm_q;
                  ctl_d          = CTL_W'(byte_sr_q);
                  crc_ok_d       = (crc_calc == byte_sr_q[2:0]);
                  result_valid_d = 1'b1;
                  byte_cnt_d     = 3'd0;
               end else if (byte_cnt_q == 3'd0 && byte_sr_q[7]) begin
                  ctl_d       = CTL_W'(byte_sr_q);
                  err_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  byte_cnt_d  = 3'd0;
               end
            end else begin
               frame_err_d = 1'b1;
               byte_cnt_d  = 3'd0;
               state_d     = StHunt;
            end
         end
         StHunt: begin
            // Wait for the line to return high so a stuck-low line cannot retrigger.
            if (sin) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign C_out        = c_out_q;
   assign CTL_rx       = ctl_q;
   assign crc_ok       = crc_ok_q;
   assign result_valid = result_valid_q;
   assign err_valid    = err_valid_q;
   assign frame_err    = frame_err_q;

endmodule
